// File: rtl/sysctrl_pkg.sv
// Shared definitions for the MCU-link system-control target: command codes,
// identification bytes and the command FSM state type.
package sysctrl_pkg;

  localparam logic [7:0] CMD_ID      = 8'h01;
  localparam logic [7:0] CMD_LEDS    = 8'h02;
  localparam logic [7:0] CMD_BUTTONS = 8'h03;
  localparam logic [7:0] CMD_CFG_WR  = 8'h04;
  localparam logic [7:0] CMD_CFG_RD  = 8'h05;
  localparam logic [7:0] CMD_INT_ACK = 8'h06;
  localparam logic [7:0] CMD_RTC     = 8'h07;

  localparam logic [7:0] ID_BYTE0 = 8'h5C;
  localparam logic [7:0] ID_BYTE1 = 8'h42;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CMD     = 2'd1,
    S_PAYLOAD = 2'd2
  } state_e;

endpackage

// File: rtl/sysctrl.sv
// System-control target: decodes MCU command bytes into config/LED/button registers,
// interrupt pending/ack and ID replies. Optional RTC command under SYSCTRL_RTC_EN.
module sysctrl
  import sysctrl_pkg::*;
#(
  parameter logic [7:0] CORE_ID  = 8'h01,
  parameter int         CFG_REGS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  data_in_strobe,
  input  logic                  data_in_start,
  input  logic [7:0]            data_in,
  output logic [7:0]            data_out,
  input  logic [7:0]            int_in,
  output logic                  int_out,
  output logic [8*CFG_REGS-1:0] cfg_out,
  output logic [7:0]            buttons,
  output logic [7:0]            leds
`ifdef SYSCTRL_RTC_EN
  ,
  output logic [63:0]           rtc_out,
  output logic                  rtc_strobe
`endif
);

  localparam int IW = (CFG_REGS > 1) ? $clog2(CFG_REGS) : 1;

  state_e                       state_q, state_d;
  logic [7:0]                   cmd_q, cmd_d;
  logic [7:0]                   byte_cnt_q, byte_cnt_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic [CFG_REGS-1:0][7:0]     cfg_q, cfg_d;
  logic [7:0]                   data_out_q, data_out_d;
  logic [7:0]                   int_pending_q, int_pending_d;
  logic                         int_out_q, int_out_d;
  logic [7:0]                   buttons_q, buttons_d;
  logic [7:0]                   leds_q, leds_d;
`ifdef SYSCTRL_RTC_EN
  logic [55:0]                  rtc_buf_q, rtc_buf_d;
  logic [63:0]                  rtc_out_q, rtc_out_d;
  logic                         rtc_strobe_q, rtc_strobe_d;
`endif

  always_comb begin
    state_d       = state_q;
    cmd_d         = cmd_q;
    byte_cnt_d    = byte_cnt_q;
    idx_d         = idx_q;
    cfg_d         = cfg_q;
    data_out_d    = data_out_q;
    int_pending_d = int_pending_q | int_in;
    buttons_d     = buttons_q;
    leds_d        = leds_q;
`ifdef SYSCTRL_RTC_EN
    rtc_buf_d     = rtc_buf_q;
    rtc_out_d     = rtc_out_q;
    rtc_strobe_d  = 1'b0;
`endif
    if (data_in_strobe) begin
      if (data_in_start) begin
        state_d    = S_CMD;
        cmd_d      = data_in;
        byte_cnt_d = 8'd0;
        data_out_d = 8'h00;
        case (data_in)
          CMD_ID:      data_out_d = ID_BYTE0;
          // Clear and snapshot in one cycle; a source firing now survives the clear.
          CMD_INT_ACK: begin
            data_out_d    = int_pending_q;
            int_pending_d = int_in;
          end
          default: ;
        endcase
      end else if (state_q == S_IDLE) begin
        data_out_d = 8'h00;
      end else begin
        state_d    = S_PAYLOAD;
        data_out_d = 8'h00;
        if (byte_cnt_q != 8'hFF) byte_cnt_d = byte_cnt_q + 8'd1;
        case (cmd_q)
          CMD_ID: begin
            if (byte_cnt_q == 8'd0)      data_out_d = ID_BYTE1;
            else if (byte_cnt_q == 8'd1) data_out_d = CORE_ID;
          end
          CMD_LEDS:    if (byte_cnt_q == 8'd0) leds_d = data_in;
          CMD_BUTTONS: if (byte_cnt_q == 8'd0) buttons_d = data_in;
          CMD_CFG_WR: begin
            if (byte_cnt_q == 8'd0) idx_d = data_in[IW-1:0];
            else begin
              cfg_d[idx_q] = data_in;
              idx_d        = IW'(idx_q + 1'b1);
            end
          end
          CMD_CFG_RD: begin
            if (byte_cnt_q == 8'd0) idx_d = data_in[IW-1:0];
            else begin
              data_out_d = cfg_q[idx_q];
              idx_d      = IW'(idx_q + 1'b1);
            end
          end
`ifdef SYSCTRL_RTC_EN
          // Bytes collect in a shadow so a partial transfer never disturbs rtc_out.
          CMD_RTC: begin
            if (byte_cnt_q < 8'd7)
              rtc_buf_d[{byte_cnt_q[2:0], 3'b000} +: 8] = data_in;
            else if (byte_cnt_q == 8'd7) begin
              rtc_out_d    = {data_in, rtc_buf_q};
              rtc_strobe_d = 1'b1;
            end
          end
`endif
          default: ;
        endcase
      end
    end
    int_out_d = |int_pending_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cmd_q         <= 8'h00;
      byte_cnt_q    <= 8'd0;
      idx_q         <= '0;
      cfg_q         <= '0;
      data_out_q    <= 8'h00;
      int_pending_q <= 8'h00;
      int_out_q     <= 1'b0;
      buttons_q     <= 8'h00;
      leds_q        <= 8'h00;
`ifdef SYSCTRL_RTC_EN
      rtc_buf_q     <= '0;
      rtc_out_q     <= '0;
      rtc_strobe_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cmd_q         <= cmd_d;
      byte_cnt_q    <= byte_cnt_d;
      idx_q         <= idx_d;
      cfg_q         <= cfg_d;
      data_out_q    <= data_out_d;
      int_pending_q <= int_pending_d;
      int_out_q     <= int_out_d;
      buttons_q     <= buttons_d;
      leds_q        <= leds_d;
`ifdef SYSCTRL_RTC_EN
      rtc_buf_q     <= rtc_buf_d;
      rtc_out_q     <= rtc_out_d;
      rtc_strobe_q  <= rtc_strobe_d;
`endif
    end
  end

  assign data_out = data_out_q;
  assign int_out  = int_out_q;
  assign cfg_out  = cfg_q;
  assign buttons  = buttons_q;
  assign leds     = leds_q;
`ifdef SYSCTRL_RTC_EN
  assign rtc_out    = rtc_out_q;
  assign rtc_strobe = rtc_strobe_q;
`endif

endmodule

// File: tb/tb_sysctrl.sv
// Scoreboard bench for sysctrl: each strobed byte queues its expected reply,
// a monitor compares data_out one edge later; register outputs checked directly.
module tb_sysctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         data_in_strobe = 1'b0;
  logic         data_in_start = 1'b0;
  logic [7:0]   data_in = 8'h00;
  logic [7:0]   data_out;
  logic [7:0]   int_in = 8'h00;
  logic         int_out;
  logic [127:0] cfg_out;
  logic [7:0]   buttons;
  logic [7:0]   leds;
`ifdef SYSCTRL_RTC_EN
  logic [63:0]  rtc_out;
  logic         rtc_strobe;
  int           rtc_pulses = 0;
`endif

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  sysctrl #(.CORE_ID(8'h01), .CFG_REGS(16)) dut (
    .clk(clk), .reset(reset),
    .data_in_strobe(data_in_strobe), .data_in_start(data_in_start), .data_in(data_in),
    .data_out(data_out), .int_in(int_in), .int_out(int_out),
    .cfg_out(cfg_out), .buttons(buttons), .leds(leds)
`ifdef SYSCTRL_RTC_EN
    , .rtc_out(rtc_out), .rtc_strobe(rtc_strobe)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reply monitor: a byte strobed at this edge is answered on data_out right after it.
  initial forever begin
    @(posedge clk);
    if (data_in_strobe && !reset) begin
      #2;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL reply_unexpected: got %0h expected none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          failures++;
          $display("FAIL reply: got %0h expected %0h", data_out, e);
        end
      end
    end
  end

`ifdef SYSCTRL_RTC_EN
  initial forever begin
    @(posedge clk);
    #1;
    if (rtc_strobe) rtc_pulses++;
  end
`endif

  task automatic send(input logic start, input logic [7:0] d, input logic [7:0] exp);
    @(posedge clk); #1;
    data_in_strobe = 1'b1;
    data_in_start  = start;
    data_in        = d;
    exp_q.push_back(exp);
    @(posedge clk); #1;
    data_in_strobe = 1'b0;
    data_in_start  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(3);
    reset = 1'b0;
    chk("rst_data_out", {56'd0, data_out}, 64'h0);
    chk("rst_int_out", {63'd0, int_out}, 64'h0);
    chk("rst_cfg", cfg_out[63:0] | cfg_out[127:64], 64'h0);
    chk("rst_buttons_leds", {48'd0, buttons, leds}, 64'h0);

    send(1'b0, 8'h33, 8'h00);  // strobe without start while idle

    // Identification sequence
    send(1'b1, 8'h01, 8'h5C);
    send(1'b0, 8'h00, 8'h42);
    send(1'b0, 8'h00, 8'h01);
    send(1'b0, 8'h00, 8'h00);

    // Config write with index wrap, then read back
    send(1'b1, 8'h04, 8'h00);
    send(1'b0, 8'h0F, 8'h00);
    send(1'b0, 8'hAA, 8'h00);
    send(1'b0, 8'hBB, 8'h00);
    chk("cfg15", {56'd0, cfg_out[8*15 +: 8]}, 64'hAA);
    chk("cfg0", {56'd0, cfg_out[7:0]}, 64'hBB);
    send(1'b1, 8'h05, 8'h00);
    send(1'b0, 8'h0F, 8'h00);
    send(1'b0, 8'h00, 8'hAA);
    send(1'b0, 8'h00, 8'hBB);
    idle(4);
    chk("data_out_hold", {56'd0, data_out}, 64'hBB);
    send(1'b1, 8'h09, 8'h00);  // unknown command
    send(1'b0, 8'h55, 8'h00);

    // Interrupts
    @(posedge clk); #1; int_in = 8'h05;
    @(posedge clk); #1; int_in = 8'h00;
    chk("int_out_set", {63'd0, int_out}, 64'h1);
    send(1'b1, 8'h06, 8'h05);
    chk("int_out_clr", {63'd0, int_out}, 64'h0);
    @(posedge clk); #1; int_in = 8'h05;
    @(posedge clk); #1; int_in = 8'h02;
    data_in_strobe = 1'b1; data_in_start = 1'b1; data_in = 8'h06;
    exp_q.push_back(8'h05);
    @(posedge clk); #1;
    data_in_strobe = 1'b0; data_in_start = 1'b0; int_in = 8'h00;
    chk("int_set_wins", {63'd0, int_out}, 64'h1);
    send(1'b1, 8'h06, 8'h02);
    chk("int_out_clr2", {63'd0, int_out}, 64'h0);

    // Abort a config write with a new command
    send(1'b1, 8'h04, 8'h00);
    send(1'b0, 8'h02, 8'h00);
    send(1'b0, 8'h11, 8'h00);
    send(1'b1, 8'h02, 8'h00);
    send(1'b0, 8'h3C, 8'h00);
    send(1'b0, 8'h77, 8'h00);  // extra LED byte ignored
    chk("abort_cfg2", {56'd0, cfg_out[8*2 +: 8]}, 64'h11);
    chk("abort_cfg3", {56'd0, cfg_out[8*3 +: 8]}, 64'h00);
    chk("leds", {56'd0, leds}, 64'h3C);
    send(1'b1, 8'h03, 8'h00);
    send(1'b0, 8'h81, 8'h00);
    chk("buttons", {56'd0, buttons}, 64'h81);

`ifdef SYSCTRL_RTC_EN
    send(1'b1, 8'h07, 8'h00);
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), 8'h00);
    idle(2);
    chk("rtc_out", rtc_out, 64'h0807060504030201);
    chk("rtc_pulses", 64'(rtc_pulses), 64'd1);
    send(1'b1, 8'h07, 8'h00);
    for (int i = 0; i < 7; i++) send(1'b0, 8'h90, 8'h00);
    idle(2);
    chk("rtc_partial_pulses", 64'(rtc_pulses), 64'd1);
    chk("rtc_partial_out", rtc_out, 64'h0807060504030201);
`endif

    // Reset in the middle of a config write
    send(1'b1, 8'h01, 8'h5C);
    send(1'b1, 8'h04, 8'h00);
    send(1'b0, 8'h05, 8'h00);
    @(posedge clk); #1; int_in = 8'h80;
    @(posedge clk); #1; int_in = 8'h00; reset = 1'b1;
    idle(2);
    reset = 1'b0;
    chk("mid_rst_cfg", cfg_out[63:0] | cfg_out[127:64], 64'h0);
    chk("mid_rst_regs", {40'd0, buttons, leds, data_out}, 64'h0);
    chk("mid_rst_int", {63'd0, int_out}, 64'h0);
    send(1'b0, 8'h77, 8'h00);
    chk("post_rst_ignored", cfg_out[63:0] | cfg_out[127:64], 64'h0);
    send(1'b1, 8'h06, 8'h00);  // pending cleared by reset

    begin
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
        @(posedge clk); n++;
      end
    end
    idle(2);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
